// File: rtl/prefetch_issuer.sv
// Consumer of the prefetcher's address stream: line-aligns, filters recent
// duplicates, queues requests and issues single-beat AXI reads with an outstanding cap.
module prefetch_issuer #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned FILTER_ENTRIES  = 4,
    parameter int unsigned LOG_LINE        = 6,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ARID            = 0,
    parameter logic [31:0] REG_ENABLE_ADDR = 32'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prefetch_valid,
    input  logic [63:0] prefetch_addr,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [63:0] m_araddr,
    output logic [7:0]  m_arid,
    output logic [7:0]  m_arlen,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready,
    input  logic        reg_bus_wvalid,
    input  logic [31:0] reg_bus_waddr,
    input  logic [31:0] reg_bus_wdata,
    output logic [15:0] drop_count
);

    localparam int unsigned LINE_W = 64 - LOG_LINE;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FP_W   = $clog2(FILTER_ENTRIES);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic                enable;
    logic [LINE_W-1:0]   in_line;
    logic [LINE_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      fifo_count;
    logic [LINE_W-1:0]   filt_line [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] filt_valid;
    logic [FP_W-1:0]     filt_ptr;
    logic [OUT_W-1:0]    outstanding;
    logic                filt_hit, fifo_full, fifo_empty;
    logic                accept, push, drop, pop, r_done;
    logic                unused_bits;

    assign in_line    = prefetch_addr[63:LOG_LINE];
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign accept     = prefetch_valid & enable & ~filt_hit;
    // Fullness is judged on the registered count, so a same-cycle pop never frees room.
    assign push       = accept & ~fifo_full;
    assign drop       = accept & fifo_full;

    // Valid and address are pure functions of registered state, so they hold until the handshake.
    assign m_arvalid  = ~fifo_empty & (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign m_araddr   = m_arvalid ? {mem[rd_ptr], {LOG_LINE{1'b0}}} : '0;
    assign m_arid     = 8'(ARID);
    assign m_arlen    = '0;
    assign pop        = m_arvalid & m_arready;
    assign r_done     = m_rvalid & m_rlast;

    assign unused_bits = ^{reg_bus_wdata[31:1], prefetch_addr[LOG_LINE-1:0]};

    always_comb begin
        filt_hit = 1'b0;
        for (int unsigned i = 0; i < FILTER_ENTRIES; i++) begin
            if (filt_valid[i] && (filt_line[i] == in_line)) filt_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]         <= in_line;
            filt_line[filt_ptr] <= in_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable      <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            filt_valid  <= '0;
            filt_ptr    <= '0;
            outstanding <= '0;
            drop_count  <= '0;
            m_rready    <= 1'b0;
        end else begin
            m_rready <= 1'b1;
            if (reg_bus_wvalid && (reg_bus_waddr == REG_ENABLE_ADDR)) enable <= reg_bus_wdata[0];

            if (push) begin
                wr_ptr               <= wr_ptr + 1'b1;
                filt_valid[filt_ptr] <= 1'b1;
                filt_ptr <= (filt_ptr == FP_W'(FILTER_ENTRIES - 1)) ? '0 : filt_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;

            if (pop && !r_done)
                outstanding <= outstanding + 1'b1;
            else if (!pop && r_done && (outstanding != '0))
                outstanding <= outstanding - 1'b1;
        end
    end

endmodule
